actor_motion: RTL and testbench
===============================

# actor_motion

Parametrised successor to the single-player movement block. It moves one hitbox-sized actor per frame from a 4-bit direction vector, with diagonal moves allowed. Each candidate position is checked against the level wall map through a sequential 4-corner probe, and diagonals blocked by a wall slide along it. Room-edge crossings produce a door code plus wraparound. One instance per actor (player, enemies) sits between the key decoder and the sprite/level_rom path.

## Interface
Parameters:
- X_MAX, 639: rightmost pixel column.
- Y_MAX, 479: bottom pixel row.
- STEP, 3: pixels moved per frame, per axis.
- SIZE, 16: hitbox edge length in pixels.
- EDGE, 32: room-edge margin in pixels.
- START_X, 304: reset X position.
- START_Y, 400: reset Y position.

Ports:
- Clk  in  1  system clock; one clock; all state on posedge Clk.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_clk  in  1  VGA vsync-rate frame clock; its rising edge is detected internally.
- dir  in  4  {up, down, left, right}; any combination allowed.
- probe_x, probe_y  out  10  wall-map query coordinate.
- probe_is_wall  in  1  wall result for the probe issued on the previous cycle; the ROM is registered, latency 1.
- Player_X, Player_Y  out  10  top-left corner of the hitbox.
- doorcode  out  3  last door taken: 0 none, 1 east, 2 west, 3 north, 4 south.
- door_pulse  out  1  one-cycle strobe when doorcode is updated.
- busy  out  1  high while the state machine is not in IDLE.

## Operation
- Wrap bounds: X_LO = Y_LO = EDGE; X_HI = X_MAX+1-EDGE-SIZE (592); Y_HI = Y_MAX+1-EDGE-SIZE (432).
- Frame tick: frame_clk is registered, and a tick is the cycle where frame_clk = 1 and the registered copy = 0. A tick that arrives while busy is dropped.
- State machine: IDLE, EDGE, CAND, PROBE, DECIDE, COMMIT.
- IDLE: a tick moves to EDGE. dir is sampled at this transition and held for the whole move.
- EDGE: the current position is checked in priority order; the first match applies:
  - Y < Y_LO: door 3, Y := Y_HI.
  - Y > Y_HI: door 4, Y := Y_LO.
  - X < X_LO: door 2, X := X_HI.
  - X > X_HI: door 1, X := X_LO.
- EDGE outcome: on a match, doorcode is set, door_pulse fires and the state returns to IDLE; there is no motion on that frame. With no match, doorcode := 0 and the state goes to CAND.
- Direction deltas: dx = +STEP for right, -STEP for left, 0 if both or neither are set; dy is the same using down/up.
- Zero move: if dx = dy = 0, the state goes directly to IDLE and the position is unchanged.
- Candidate list, tried in order:
  - C0 = (X+dx, Y+dy).
  - If both dx and dy are nonzero: C1 = (X+dx, Y), then C2 = (X, Y+dy).
- Candidate arithmetic: 11-bit signed. Results are clamped to [0, X_MAX+1-SIZE] for X and [0, Y_MAX+1-SIZE] for Y.
- CAND: loads the next candidate and goes to PROBE.
- PROBE: issues the 4 corners on 4 consecutive cycles: (cx,cy), (cx+SIZE-1,cy), (cx,cy+SIZE-1), (cx+SIZE-1,cy+SIZE-1). Each probe_is_wall result is ORed into a hit flag one cycle after its corner is issued.
- DECIDE: runs the cycle after the last result arrives.
  - Hit clear: go to COMMIT.
  - Hit set and candidates remain: go to CAND.
  - Hit set and no candidates remain: go to IDLE, position unchanged.
- COMMIT: Player_X/Player_Y := candidate, then IDLE.
- Reset_n low, at any state: returns to IDLE asynchronously. Player_X = START_X, Player_Y = START_Y, doorcode = 0, door_pulse = 0, busy = 0, probe_x = probe_y = 0.

## Timing
- Tick detection adds 1 cycle; the state leaves IDLE on the cycle after the tick.
- Per candidate: CAND 1 cycle + PROBE 4 cycles + 1 cycle trailing result + DECIDE 1 cycle = 7 cycles.
- Latency from the IDLE exit to the position update:
  - Clear orthogonal move: EDGE 1 + 7 + COMMIT 1 = 9 cycles.
  - Worst case, diagonal with C2 accepted: 1 + 21 + 1 = 23 cycles.
  - Door frame: 1 cycle.
- Player_X/Player_Y change only in COMMIT or EDGE, and are stable at all other times.
- probe_x/probe_y are registered and hold their last value outside PROBE.
- busy rises in the cycle the state leaves IDLE and falls in the cycle it returns to IDLE.
- Requirement: the frame period must exceed 23 cycles. This is guaranteed at 50 MHz / 60 Hz.

## Test plan
- Reset: Reset_n low mid-PROBE, then released -> Player_X=304, Player_Y=400, doorcode=0, busy=0; the next tick behaves normally.
- Clear move: dir=right, empty wall map -> X=307, busy high for exactly 9 cycles after the IDLE exit, probes at (307,400), (322,400), (307,415), (322,415).
- Slide: dir=up+right, wall only at (322,397) -> C0 rejected, C1 committed, X=307, Y=400; latency 16 cycles.
- Fully blocked: dir=up+left with all probes returning walls -> position unchanged, 3 candidates probed (12 probe cycles), no door_pulse.
- Door north: Y=20, any dir -> doorcode=3, door_pulse for 1 cycle, Y=432, X unchanged, no probes issued. Then Y=440 -> doorcode=4, Y=32.
- Dropped tick and cancellation: a second tick during busy is ignored; dir=left+right gives a zero move with position unchanged.

Source files
------------

// File: rtl/actor_motion_if.sv
// Wall-map probe bus between a moving actor and the level ROM.
// The ROM answers probe_is_wall one cycle after it sees a coordinate.
interface actor_motion_if;
    logic [9:0] probe_x;
    logic [9:0] probe_y;
    logic       probe_is_wall;

    modport master (output probe_x, output probe_y, input probe_is_wall);
    modport slave  (input probe_x, input probe_y, output probe_is_wall);
endinterface

// File: rtl/actor_motion.sv
// Per-frame actor mover: room-edge doors, candidate moves with diagonal slide,
// and a 4-corner hitbox probe against a latency-1 wall ROM.
module actor_motion #(
    parameter int X_MAX   = 639,
    parameter int Y_MAX   = 479,
    parameter int STEP    = 3,
    parameter int SIZE    = 16,
    parameter int EDGE    = 32,
    parameter int START_X = 304,
    parameter int START_Y = 400
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_clk,
    input  logic [3:0]           dir,
    actor_motion_if.master       probe,
    output logic [9:0]           Player_X,
    output logic [9:0]           Player_Y,
    output logic [2:0]           doorcode,
    output logic                 door_pulse,
    output logic                 busy
);

    localparam logic [9:0] X_LO = 10'(EDGE);
    localparam logic [9:0] Y_LO = 10'(EDGE);
    localparam logic [9:0] X_HI = 10'(X_MAX + 1 - EDGE - SIZE);
    localparam logic [9:0] Y_HI = 10'(Y_MAX + 1 - EDGE - SIZE);
    localparam logic signed [10:0] X_CMAX = 11'(X_MAX + 1 - SIZE);
    localparam logic signed [10:0] Y_CMAX = 11'(Y_MAX + 1 - SIZE);
    localparam logic [9:0] OFS = 10'(SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_EDGE, S_CAND, S_PROBE, S_DECIDE, S_COMMIT
    } state_t;

    state_t      state_q, state_d;
    logic        frame_q;
    logic [3:0]  dir_q, dir_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        hit_q, hit_d;
    logic [9:0]  cx_q, cx_d, cy_q, cy_d;
    logic [9:0]  px_q, px_d, py_q, py_d;
    logic [9:0]  probe_x_q, probe_x_d, probe_y_q, probe_y_d;
    logic [2:0]  door_q, door_d;
    logic        door_pulse_q, door_pulse_d;

    logic              tick;
    logic signed [10:0] dx, dy;
    logic [9:0]        mx, my, cand_x, cand_y;
    logic [1:0]        last_idx;

    function automatic logic [9:0] clamp(input logic signed [10:0] v,
                                         input logic signed [10:0] hi);
        if (v[10])      return '0;
        else if (v > hi) return hi[9:0];
        else            return v[9:0];
    endfunction

    assign tick = frame_clk & ~frame_q;

    // dir = {up, down, left, right}; opposing keys cancel on their axis.
    always_comb begin
        dx = '0;
        dy = '0;
        if (dir_q[0] && !dir_q[1]) dx = 11'(STEP);
        if (dir_q[1] && !dir_q[0]) dx = -11'(STEP);
        if (dir_q[2] && !dir_q[3]) dy = 11'(STEP);
        if (dir_q[3] && !dir_q[2]) dy = -11'(STEP);
    end

    assign mx       = clamp($signed({1'b0, px_q}) + dx, X_CMAX);
    assign my       = clamp($signed({1'b0, py_q}) + dy, Y_CMAX);
    assign last_idx = (dx != '0 && dy != '0) ? 2'd2 : 2'd0;

    // C0 is the full move; C1/C2 slide along one axis when a diagonal is blocked.
    always_comb begin
        cand_x = mx;
        cand_y = my;
        case (idx_q)
            2'd1:    cand_y = py_q;
            2'd2:    cand_x = px_q;
            default: ;
        endcase
    end

    // NOTE: every variable gets its default first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        hit_d        = hit_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        px_d         = px_q;
        py_d         = py_q;
        probe_x_d    = probe_x_q;
        probe_y_d    = probe_y_q;
        door_d       = door_q;
        door_pulse_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_EDGE;
                    dir_d   = dir;
                end
            end
            S_EDGE: begin
                idx_d = '0;
                if (py_q < Y_LO) begin
                    door_d = 3'd3; py_d = Y_HI; door_pulse_d = 1'b1; state_d = S_IDLE;
                end else if (py_q > Y_HI) begin
                    door_d = 3'd4; py_d = Y_LO; door_pulse_d = 1'b1; state_d = S_IDLE;
                end else if (px_q < X_LO) begin
                    door_d = 3'd2; px_d = X_HI; door_pulse_d = 1'b1; state_d = S_IDLE;
                end else if (px_q > X_HI) begin
                    door_d = 3'd1; px_d = X_LO; door_pulse_d = 1'b1; state_d = S_IDLE;
                end else begin
                    door_d  = 3'd0;
                    state_d = (dx == '0 && dy == '0) ? S_IDLE : S_CAND;
                end
            end
            S_CAND: begin
                cx_d      = cand_x;
                cy_d      = cand_y;
                probe_x_d = cand_x;
                probe_y_d = cand_y;
                hit_d     = 1'b0;
                cnt_d     = '0;
                state_d   = S_PROBE;
            end
            S_PROBE: begin
                // cnt 0..3 issue corners; wall results trail by one cycle, so cnt 1..4 collect them.
                cnt_d = cnt_q + 3'd1;
                if (cnt_q != 3'd0) hit_d = hit_q | probe.probe_is_wall;
                case (cnt_q)
                    3'd0: begin probe_x_d = cx_q + OFS; probe_y_d = cy_q;       end
                    3'd1: begin probe_x_d = cx_q;       probe_y_d = cy_q + OFS; end
                    3'd2: begin probe_x_d = cx_q + OFS; probe_y_d = cy_q + OFS; end
                    default: ;
                endcase
                if (cnt_q == 3'd4) state_d = S_DECIDE;
            end
            S_DECIDE: begin
                if (!hit_q) begin
                    state_d = S_COMMIT;
                end else if (idx_q != last_idx) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_CAND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COMMIT: begin
                px_d    = cx_q;
                py_d    = cy_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            frame_q      <= 1'b0;
            dir_q        <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            hit_q        <= 1'b0;
            cx_q         <= '0;
            cy_q         <= '0;
            px_q         <= 10'(START_X);
            py_q         <= 10'(START_Y);
            probe_x_q    <= '0;
            probe_y_q    <= '0;
            door_q       <= '0;
            door_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_clk;
            dir_q        <= dir_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            hit_q        <= hit_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            px_q         <= px_d;
            py_q         <= py_d;
            probe_x_q    <= probe_x_d;
            probe_y_q    <= probe_y_d;
            door_q       <= door_d;
            door_pulse_q <= door_pulse_d;
        end
    end

    assign probe.probe_x = probe_x_q;
    assign probe.probe_y = probe_y_q;
    assign Player_X      = px_q;
    assign Player_Y      = py_q;
    assign doorcode      = door_q;
    assign door_pulse    = door_pulse_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_actor_motion.sv
// Directed bench for actor_motion: reset, clear move, slide, full block,
// dropped tick, zero move and north/south doors against a modelled wall ROM.
module tb_actor_motion;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic [3:0] dir = '0;
    logic [9:0] Player_X, Player_Y;
    logic [2:0] doorcode;
    logic       door_pulse, busy;

    actor_motion_if probe_bus ();

    actor_motion dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .dir        (dir),
        .probe      (probe_bus.master),
        .Player_X   (Player_X),
        .Player_Y   (Player_Y),
        .doorcode   (doorcode),
        .door_pulse (door_pulse),
        .busy       (busy)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    // Wall map: 0 empty, 1 single wall pixel at (wall_x, wall_y), 2 solid.
    int         wall_mode = 0;
    logic [9:0] wall_x = '0, wall_y = '0;

    always @(posedge Clk) begin
        case (wall_mode)
            1:       probe_bus.probe_is_wall <= (probe_bus.probe_x == wall_x) && (probe_bus.probe_y == wall_y);
            2:       probe_bus.probe_is_wall <= 1'b1;
            default: probe_bus.probe_is_wall <= 1'b0;
        endcase
    end

    // Per-frame capture, indexed by cycles since the IDLE exit (0 = EDGE).
    logic [9:0] lx [0:63];
    logic [9:0] ly [0:63];
    int nb;
    int pulses;

    task automatic apply_reset();
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic run_frame();
        nb = 0;
        pulses = 0;
        @(negedge Clk);
        frame_clk = 1'b1;
        @(posedge Clk);
        for (int k = 0; k < 64; k++) begin
            @(negedge Clk);
            if (door_pulse) pulses++;
            if (!busy) break;
            lx[k] = probe_bus.probe_x;
            ly[k] = probe_bus.probe_y;
            nb++;
        end
        repeat (2) begin
            @(negedge Clk);
            if (door_pulse) pulses++;
        end
        frame_clk = 1'b0;
    endtask

    task automatic chk_pos(input string name, input int ex, input int ey);
        checks++;
        if (Player_X !== 10'(ex) || Player_Y !== 10'(ey)) begin
            failures++;
            $display("FAIL %s pos got=(%0d,%0d) exp=(%0d,%0d)", name, Player_X, Player_Y, ex, ey);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic chk_probe(input string name, input int k, input int ex, input int ey);
        checks++;
        if (lx[k] !== 10'(ex) || ly[k] !== 10'(ey)) begin
            failures++;
            $display("FAIL %s probe[%0d] got=(%0d,%0d) exp=(%0d,%0d)", name, k, lx[k], ly[k], ex, ey);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        chk_pos("reset", 304, 400);
        chk_int("reset_door", int'(doorcode), 0);
        chk_int("reset_busy", int'(busy), 0);
        chk_int("reset_pulse", int'(door_pulse), 0);
        chk_int("reset_probe_x", int'(probe_bus.probe_x), 0);
        chk_int("reset_probe_y", int'(probe_bus.probe_y), 0);
    endtask

    task automatic test_clear_move();
        apply_reset();
        wall_mode = 0;
        dir = 4'b0001;
        run_frame();
        chk_int("clear_busy_cycles", nb, 9);
        chk_pos("clear", 307, 400);
        chk_probe("clear", 2, 307, 400);
        chk_probe("clear", 3, 322, 400);
        chk_probe("clear", 4, 307, 415);
        chk_probe("clear", 5, 322, 415);
        chk_int("clear_door", int'(doorcode), 0);
        chk_int("clear_pulses", pulses, 0);
    endtask

    task automatic test_slide();
        apply_reset();
        wall_mode = 1;
        wall_x = 10'd322;
        wall_y = 10'd397;
        dir = 4'b1001;
        run_frame();
        chk_int("slide_busy_cycles", nb, 16);
        chk_pos("slide", 307, 400);
        chk_probe("slide_c0", 2, 307, 397);
        chk_probe("slide_c1", 9, 307, 400);
        chk_probe("slide_c1", 12, 322, 415);
        wall_mode = 0;
    endtask

    task automatic test_blocked();
        apply_reset();
        wall_mode = 2;
        dir = 4'b1010;
        run_frame();
        chk_int("blocked_busy_cycles", nb, 22);
        chk_pos("blocked", 304, 400);
        chk_probe("blocked_c0", 2, 301, 397);
        chk_probe("blocked_c0", 5, 316, 412);
        chk_probe("blocked_c1", 9, 301, 400);
        chk_probe("blocked_c1", 12, 316, 415);
        chk_probe("blocked_c2", 16, 304, 397);
        chk_probe("blocked_c2", 19, 319, 412);
        chk_int("blocked_pulses", pulses, 0);
        wall_mode = 0;
    endtask

    task automatic test_reset_mid_probe();
        apply_reset();
        dir = 4'b0001;
        @(negedge Clk);
        frame_clk = 1'b1;
        @(posedge Clk);
        repeat (4) @(negedge Clk);
        chk_int("midprobe_busy_before", int'(busy), 1);
        Reset_n = 1'b0;
        #1;
        chk_int("midprobe_busy", int'(busy), 0);
        chk_pos("midprobe", 304, 400);
        chk_int("midprobe_door", int'(doorcode), 0);
        chk_int("midprobe_probe_x", int'(probe_bus.probe_x), 0);
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        run_frame();
        chk_int("after_reset_busy_cycles", nb, 9);
        chk_pos("after_reset", 307, 400);
    endtask

    task automatic test_back_to_back();
        int b;
        apply_reset();
        dir = 4'b0001;
        b = 0;
        @(negedge Clk);
        frame_clk = 1'b1;
        @(posedge Clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (k == 3) frame_clk = 1'b0;
            if (k == 4) frame_clk = 1'b1;
            if (busy) b++;
        end
        frame_clk = 1'b0;
        chk_int("dropped_tick_busy_cycles", b, 9);
        chk_pos("dropped_tick", 307, 400);
        dir = 4'b0011;
        run_frame();
        chk_int("zero_move_busy_cycles", nb, 1);
        chk_pos("zero_move", 307, 400);
        chk_int("zero_move_pulses", pulses, 0);
    endtask

    task automatic test_doors();
        logic [9:0] px_hold, py_hold;
        apply_reset();
        dir = 4'b1000;
        for (int f = 0; f < 123; f++) run_frame();
        chk_pos("walk_north", 304, 31);
        px_hold = probe_bus.probe_x;
        py_hold = probe_bus.probe_y;
        run_frame();
        chk_int("north_busy_cycles", nb, 1);
        chk_int("north_door", int'(doorcode), 3);
        chk_int("north_pulses", pulses, 1);
        chk_pos("north", 304, 432);
        chk_int("north_no_probe_x", int'(probe_bus.probe_x), int'(px_hold));
        chk_int("north_no_probe_y", int'(probe_bus.probe_y), int'(py_hold));
        dir = 4'b0100;
        run_frame();
        chk_pos("step_south", 304, 435);
        chk_int("step_south_door", int'(doorcode), 0);
        run_frame();
        chk_int("south_door", int'(doorcode), 4);
        chk_int("south_pulses", pulses, 1);
        chk_pos("south", 304, 32);
    endtask

    initial begin
        probe_bus.probe_is_wall = 1'b0;
        test_reset();
        test_clear_move();
        test_slide();
        test_blocked();
        test_reset_mid_probe();
        test_back_to_back();
        test_doors();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
